vga_layer_mixer: RTL and testbench

- Parametrised pixel compositor between the page renderers and the VGA output driver.
- Selects one of NUM_LAYERS page/overlay colour streams per pixel by fixed priority, with a background fallback.
- On a mode change it runs a frame-counted fade-out, swaps the displayed mode, then fades in.
- Output is pipelined with a fixed 2-cycle latency.

---
 rtl/vga_layer_mixer_pkg.sv | 13 +
 rtl/vga_fade_scaler.sv | 22 ++
 rtl/vga_layer_mixer.sv | 137 +++++++++++++
 tb/tb_vga_layer_mixer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_layer_mixer_pkg.sv
// Shared definitions for the VGA layer mixer: fade FSM state encoding and
// the default pixel width used by the page renderers.
package vga_layer_mixer_pkg;

  localparam int COLOR_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

endpackage

// File: rtl/vga_fade_scaler.sv
// Per-channel brightness scaler: out = (ch * level) >> SHIFT.
// level ranges 0..2**SHIFT, so the result never exceeds ch and fits CH_W bits.
module vga_fade_scaler #(
  parameter int CH_W  = 8,
  parameter int SHIFT = 4
) (
  input  logic [CH_W-1:0] ch,
  input  logic [SHIFT:0]  level,
  output logic [CH_W-1:0] scaled
);

  // Multiply-shift with a product one bit wider than ch*level strictly needs.
  function automatic logic [CH_W-1:0] fade_scale(input logic [CH_W-1:0] c,
                                                 input logic [SHIFT:0]  lv);
    logic [CH_W+SHIFT:0] prod;
    prod = {{(SHIFT+1){1'b0}}, c} * {{CH_W{1'b0}}, lv};
    return CH_W'(prod >> SHIFT);
  endfunction

  assign scaled = fade_scale(ch, level);

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority layer compositor with frame-counted fade-out / mode swap / fade-in.
// pos_data follows pos_x/pos_y by exactly two vga_clk cycles.
module vga_layer_mixer
  import vga_layer_mixer_pkg::*;
#(
  parameter int                   NUM_LAYERS  = 4,
  parameter int                   COLOR_W     = COLOR_W_DEFAULT,
  parameter int                   MODE_W      = 8,
  parameter int                   FADE_FRAMES = 16,
  parameter logic [COLOR_W-1:0]   BG_COLOR    = 24'hFFFFFF,
  parameter logic [MODE_W-1:0]    RESET_MODE  = 8'h00
) (
  input  logic                          vga_clk,
  input  logic                          rst_n,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic [MODE_W-1:0]             mode,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
  output logic [MODE_W-1:0]             mode_shown,
  output logic                          fade_busy,
  output logic [COLOR_W-1:0]            pos_data
);

  localparam int SHIFT = $clog2(FADE_FRAMES);
  localparam int LVL_W = SHIFT + 1;
  localparam int CH_W  = COLOR_W / 3;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_FRAMES);

  fade_state_t        state;
  logic [LVL_W-1:0]   level;
  logic [MODE_W-1:0]  pending;
  logic               raw, raw_q, tick;

  logic [COLOR_W-1:0] sel_color_p0;
  logic [COLOR_W-1:0] sel_color_p1;
  logic [LVL_W-1:0]   sel_level_p1;
  logic [COLOR_W-1:0] scaled_p1;

  assign raw  = (pos_x == 10'd0) && (pos_y == 10'd0);
  assign tick = raw && !raw_q;

  // Lowest-index enabled layer wins; background when none is enabled.
  always_comb begin
    sel_color_p0 = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i]) sel_color_p0 = layer_data[i*COLOR_W +: COLOR_W];
    end
  end

  // ---- stage 1: selected colour and the level it will be scaled by ----
  // Register the selected colour together with the current fade level.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      sel_color_p1 <= '0;
      sel_level_p1 <= '0;
    end else begin
      sel_color_p1 <= sel_color_p0;
      sel_level_p1 <= level;
    end
  end

  genvar c;
  generate
    for (c = 0; c < 3; c++) begin : g_ch
      vga_fade_scaler #(
        .CH_W  (CH_W),
        .SHIFT (SHIFT)
      ) u_scaler (
        .ch     (sel_color_p1[c*CH_W +: CH_W]),
        .level  (sel_level_p1),
        .scaled (scaled_p1[c*CH_W +: CH_W])
      );
    end
  endgenerate

  // ---- stage 2: faded pixel out ----
  // Register the scaled pixel as the module output.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) pos_data <= '0;
    else        pos_data <= scaled_p1;
  end

  // Fade FSM: mode comparison outranks a coincident frame tick.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= LVL_FULL;
      mode_shown <= RESET_MODE;
      pending    <= RESET_MODE;
      fade_busy  <= 1'b0;
      raw_q      <= 1'b1;
    end else begin
      raw_q <= raw;
      case (state)
        IDLE: begin
          if (mode != mode_shown) begin
            pending   <= mode;
            state     <= FADE_OUT;
            fade_busy <= 1'b1;
          end
        end
        FADE_OUT: begin
          pending <= mode;
          if (mode == mode_shown) begin
            state <= FADE_IN;
          end else if (tick) begin
            if (level != '0) begin
              level <= level - 1'b1;
            end else begin
              mode_shown <= pending;
              state      <= FADE_IN;
            end
          end
        end
        FADE_IN: begin
          if (mode != mode_shown) begin
            pending <= mode;
            state   <= FADE_OUT;
          end else if (tick) begin
            if (level != LVL_FULL) begin
              level <= level + 1'b1;
            end else begin
              state     <= IDLE;
              fade_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer with FADE_FRAMES=4 so a whole fade
// fits in a handful of short synthetic frames.
module tb_vga_layer_mixer;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pos_x, pos_y;
  logic [7:0]  mode;
  logic [3:0]  layer_en;
  logic [95:0] layer_data;
  logic [7:0]  mode_shown;
  logic        fade_busy;
  logic [23:0] pos_data;

  int checks   = 0;
  int failures = 0;

  // Pixel values for layer0 = FCFCFC at level 4,3,2,1,0 (x*level/4 per channel)
  logic [23:0] exp_fade [10];
  logic [7:0]  exp_shown [10];
  logic        exp_busy [10];

  vga_layer_mixer #(
    .NUM_LAYERS  (4),
    .COLOR_W     (24),
    .MODE_W      (8),
    .FADE_FRAMES (4),
    .BG_COLOR    (24'hFFFFFF),
    .RESET_MODE  (8'h00)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .mode       (mode),
    .layer_en   (layer_en),
    .layer_data (layer_data),
    .mode_shown (mode_shown),
    .fade_busy  (fade_busy),
    .pos_data   (pos_data)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  // One synthetic frame: origin for one cycle, then visible pixels.
  task automatic do_frame();
    pos_x = 10'd0; pos_y = 10'd0;
    step();
    pos_x = 10'd5; pos_y = 10'd5;
    step(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 8'h00; layer_en = 4'b0000; layer_data = '0;
    pos_x = 10'd5; pos_y = 10'd5;
    step(2);
    checks++;
    if (pos_data !== 24'h000000) begin
      failures++; $display("FAIL reset_pos_data: got %h want %h", pos_data, 24'h000000);
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (pos_data !== 24'hFFFFFF) begin
      failures++; $display("FAIL reset_bg: got %h want %h", pos_data, 24'hFFFFFF);
    end
    checks++;
    if (fade_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", fade_busy);
    end
    checks++;
    if (mode_shown !== 8'h00) begin
      failures++; $display("FAIL reset_mode_shown: got %h want 00", mode_shown);
    end
  endtask

  task automatic test_priority();
    layer_data = {24'h0, 24'hABCDEF, 24'h123456, 24'h0};
    layer_en = 4'b0110;
    step();
    checks++;
    if (pos_data !== 24'hFFFFFF) begin
      failures++; $display("FAIL prio_latency1: got %h want %h", pos_data, 24'hFFFFFF);
    end
    step();
    checks++;
    if (pos_data !== 24'h123456) begin
      failures++; $display("FAIL prio_latency2: got %h want %h", pos_data, 24'h123456);
    end
    layer_en = 4'b0000;
    step();
    checks++;
    if (pos_data !== 24'h123456) begin
      failures++; $display("FAIL bg_gap_before: got %h want %h", pos_data, 24'h123456);
    end
    layer_en = 4'b0110;
    step();
    checks++;
    if (pos_data !== 24'hFFFFFF) begin
      failures++; $display("FAIL bg_gap_pixel: got %h want %h", pos_data, 24'hFFFFFF);
    end
    step();
    checks++;
    if (pos_data !== 24'h123456) begin
      failures++; $display("FAIL bg_gap_after: got %h want %h", pos_data, 24'h123456);
    end
    layer_data = {24'h0, 24'hABCDEF, 24'h123456, 24'h112233};
    layer_en = 4'b1111;
    step(2);
    checks++;
    if (pos_data !== 24'h112233) begin
      failures++; $display("FAIL prio_layer0: got %h want %h", pos_data, 24'h112233);
    end
  endtask

  task automatic test_full_fade();
    layer_data = {72'h0, 24'hFCFCFC};
    layer_en = 4'b0001;
    step(3);
    checks++;
    if (pos_data !== 24'hFCFCFC) begin
      failures++; $display("FAIL fade_start_px: got %h want %h", pos_data, 24'hFCFCFC);
    end
    mode = 8'h03;
    step();
    checks++;
    if (fade_busy !== 1'b1) begin
      failures++; $display("FAIL fade_busy_rise: got %b want 1", fade_busy);
    end
    step(2);
    checks++;
    if (pos_data !== 24'hFCFCFC) begin
      failures++; $display("FAIL fade_out_first: got %h want %h", pos_data, 24'hFCFCFC);
    end
    for (int f = 0; f < 10; f++) begin
      do_frame();
      checks++;
      if (pos_data !== exp_fade[f]) begin
        failures++; $display("FAIL fade_px[%0d]: got %h want %h", f, pos_data, exp_fade[f]);
      end
      checks++;
      if (mode_shown !== exp_shown[f]) begin
        failures++; $display("FAIL fade_shown[%0d]: got %h want %h", f, mode_shown, exp_shown[f]);
      end
      checks++;
      if (fade_busy !== exp_busy[f]) begin
        failures++; $display("FAIL fade_busy[%0d]: got %b want %b", f, fade_busy, exp_busy[f]);
      end
    end
  endtask

  task automatic test_held_origin();
    mode = 8'h05;
    step();
    pos_x = 10'd0; pos_y = 10'd0;
    step(100);
    pos_x = 10'd5; pos_y = 10'd5;
    step(3);
    checks++;
    if (pos_data !== 24'hBDBDBD) begin
      failures++; $display("FAIL held_origin: got %h want %h", pos_data, 24'hBDBDBD);
    end
  endtask

  task automatic test_interrupt();
    // level 3 -> 2 -> 1 -> 0 -> swap to 5 -> 1 -> 2
    for (int f = 0; f < 6; f++) do_frame();
    checks++;
    if (mode_shown !== 8'h05) begin
      failures++; $display("FAIL int_first_swap: got %h want 05", mode_shown);
    end
    checks++;
    if (pos_data !== 24'h7E7E7E) begin
      failures++; $display("FAIL int_level2_in: got %h want %h", pos_data, 24'h7E7E7E);
    end
    mode = 8'h07;
    step(3);
    checks++;
    if (fade_busy !== 1'b1 || pos_data !== 24'h7E7E7E) begin
      failures++; $display("FAIL int_retarget: got busy=%b px=%h want busy=1 px=%h", fade_busy, pos_data, 24'h7E7E7E);
    end
    do_frame();
    checks++;
    if (pos_data !== 24'h3F3F3F) begin
      failures++; $display("FAIL int_down1: got %h want %h", pos_data, 24'h3F3F3F);
    end
    do_frame();
    checks++;
    if (pos_data !== 24'h000000 || mode_shown !== 8'h05) begin
      failures++; $display("FAIL int_down0: got px=%h shown=%h want px=000000 shown=05", pos_data, mode_shown);
    end
    do_frame();
    checks++;
    if (mode_shown !== 8'h07) begin
      failures++; $display("FAIL int_second_swap: got %h want 07", mode_shown);
    end
    for (int f = 0; f < 5; f++) do_frame();
    checks++;
    if (fade_busy !== 1'b0 || pos_data !== 24'hFCFCFC) begin
      failures++; $display("FAIL int_settle: got busy=%b px=%h want busy=0 px=%h", fade_busy, pos_data, 24'hFCFCFC);
    end
    // Revert during fade-out: back up to full without a swap.
    mode = 8'h09;
    step();
    do_frame();
    checks++;
    if (pos_data !== 24'hBDBDBD) begin
      failures++; $display("FAIL rev_down: got %h want %h", pos_data, 24'hBDBDBD);
    end
    mode = 8'h07;
    step();
    checks++;
    if (fade_busy !== 1'b1) begin
      failures++; $display("FAIL rev_busy: got %b want 1", fade_busy);
    end
    do_frame();
    checks++;
    if (pos_data !== 24'hFCFCFC || mode_shown !== 8'h07) begin
      failures++; $display("FAIL rev_up: got px=%h shown=%h want px=%h shown=07", pos_data, mode_shown, 24'hFCFCFC);
    end
    do_frame();
    checks++;
    if (fade_busy !== 1'b0) begin
      failures++; $display("FAIL rev_idle: got %b want 0", fade_busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    mode = 8'h00;
    step();
    for (int f = 0; f < 3; f++) do_frame();
    checks++;
    if (pos_data !== 24'h3F3F3F) begin
      failures++; $display("FAIL mid_level1: got %h want %h", pos_data, 24'h3F3F3F);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (fade_busy !== 1'b0 || mode_shown !== 8'h00 || pos_data !== 24'h000000) begin
      failures++; $display("FAIL mid_reset: got busy=%b shown=%h px=%h want busy=0 shown=00 px=000000", fade_busy, mode_shown, pos_data);
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (pos_data !== 24'hFCFCFC) begin
      failures++; $display("FAIL mid_full: got %h want %h", pos_data, 24'hFCFCFC);
    end
    checks++;
    if (fade_busy !== 1'b0) begin
      failures++; $display("FAIL mid_idle: got %b want 0", fade_busy);
    end
  endtask

  initial begin
    exp_fade  = '{24'hBDBDBD, 24'h7E7E7E, 24'h3F3F3F, 24'h000000, 24'h000000,
                  24'h3F3F3F, 24'h7E7E7E, 24'hBDBDBD, 24'hFCFCFC, 24'hFCFCFC};
    exp_shown = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03,
                  8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    exp_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    test_reset();
    test_priority();
    test_full_fade();
    test_held_origin();
    test_interrupt();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
